// File: rtl/tdm_demux_out_buffer.sv
// De-interleaves a TDM product stream by slot into per-channel show-ahead FIFOs.
// Define TDM_DEMUX_OVF_CNT_EN to add per-channel 8-bit saturating overflow counters (ovf_cnt).
module tdm_demux_out_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            ovf,
    output logic                         sync_err,
    output logic                         locked_o
`ifdef TDM_DEMUX_OVF_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]          ovf_cnt
`endif
);

    localparam int SW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]    state, state_next;
    logic [SW-1:0] slot, slot_next;
    logic          wr_en;
    logic [SW-1:0] wr_ch;

    // An in_sof word always re-anchors the frame at slot 0, whether locked or not.
    always_comb begin
        state_next = state;
        slot_next  = slot;
        wr_en      = 1'b0;
        wr_ch      = '0;
        sync_err   = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                wr_en      = 1'b1;
                wr_ch      = '0;
                sync_err   = (state == ST_LOCKED) && (slot != '0);
                slot_next  = SW'(1);
                state_next = ST_LOCKED;
            end else if (state == ST_LOCKED) begin
                wr_en     = 1'b1;
                wr_ch     = slot;
                slot_next = (slot == SW'(NUM_CH - 1)) ? '0 : slot + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_UNLOCKED;
            slot     <= '0;
            locked_o <= 1'b0;
        end else begin
            state    <= state_next;
            slot     <= slot_next;
            locked_o <= (state_next == ST_LOCKED);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]         rd_ptr, wr_ptr, rd_next;
        logic [CW-1:0]         count, count_next;
        logic                  wr, pop, push, full;
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] data_q, head_next;

        assign wr   = wr_en && (wr_ch == SW'(c));
        assign pop  = valid_q && out_ready[c];
        assign full = (count == CW'(FIFO_DEPTH));
        assign push = wr && (!full || pop);

        assign ovf[c]                                = wr && full && !pop;
        assign out_valid[c]                          = valid_q;
        assign out_data[c*DATA_WIDTH +: DATA_WIDTH]  = data_q;

        // A word written into an otherwise-empty FIFO bypasses memory into the head register.
        always_comb begin
            count_next = count + CW'(push) - CW'(pop);
            rd_next    = rd_ptr + PW'(pop);
            head_next  = (push && (count == CW'(pop))) ? in_data : mem[rd_next];
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_data;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                rd_ptr  <= rd_next;
                count   <= count_next;
                valid_q <= (count_next != '0);
                if (count_next != '0) data_q <= head_next;
            end
        end

`ifdef TDM_DEMUX_OVF_CNT_EN
        logic [7:0] cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (ovf[c] && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end

        assign ovf_cnt[c*8 +: 8] = cnt_q;
`endif
    end

endmodule
